vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder.sv | 131 +++++++++++++
 tb/tb_vga_sync_decoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: TinyVGA PMOD decoder with timing lock, pixel coordinates and optional frame CRC (macro VGA_DEC_CRC_EN)
module vga_sync_decoder #(
   parameter logic [9:0] H_TOTAL = 10'd800,
   parameter logic [9:0] H_SYNC  = 10'd96,
   parameter logic [9:0] H_ACT0  = 10'd144,
   parameter logic [9:0] H_ACT1  = 10'd783,
   parameter logic [9:0] V_TOTAL = 10'd525,
   parameter logic [9:0] V_SYNC  = 10'd2,
   parameter logic [9:0] V_ACT0  = 10'd35,
   parameter logic [9:0] V_ACT1  = 10'd514
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  vga_in,
   output logic        locked,
   output logic        pix_valid,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [5:0]  rgb,
   output logic        frame_done,
   output logic        timing_err,
   output logic [15:0] frame_crc
);
   typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;
   state_t state_q, state_d;
   logic [7:0] s1_q;
   logic [1:0] s2_q;
   logic [9:0] h_q, l_q, h_cnt, line_cnt;
   logic err_q, err_d;
   logic hs_fall, hs_rise, vs_fall, vs_rise, lost, bad, active;
   logic pv_q, pv_d, fd_q, fd_d, te_q, te_d;
   logic [9:0] px_q, px_d, py_q, py_d;
   logic [5:0] rgb_q, rgb_d;
   assign hs_fall = s2_q[1] & ~s1_q[7];
   assign hs_rise = ~s2_q[1] & s1_q[7];
   assign vs_fall = s2_q[0] & ~s1_q[3];
   assign vs_rise = ~s2_q[0] & s1_q[3];
   assign h_cnt = hs_fall ? 10'd0 : (&h_q ? h_q : h_q + 10'd1);
   assign line_cnt = vs_fall ? 10'd0 : (hs_fall ? l_q + 10'd1 : l_q);
   assign lost = &h_cnt;
   // line total counts hsync falls, so a coincident hsync fall is the frame's last line
   assign bad = (hs_fall && ({1'b0, h_q} + 11'd1 != {1'b0, H_TOTAL}))
              | (hs_rise && (h_cnt != H_SYNC))
              | (vs_fall && ({1'b0, l_q} + {10'd0, hs_fall} != {1'b0, V_TOTAL}))
              | (vs_rise && (line_cnt != V_SYNC));
   assign active = h_cnt >= H_ACT0 && h_cnt <= H_ACT1 && line_cnt >= V_ACT0 && line_cnt <= V_ACT1;
   assign pv_d = state_d == LOCKED && active;
   assign fd_d = vs_fall && state_q == LOCKED && state_d == LOCKED;
   assign px_d = pv_d ? h_cnt - H_ACT0 : px_q;
   assign py_d = pv_d ? line_cnt - V_ACT0 : py_q;
   assign rgb_d = pv_d ? {s1_q[0], s1_q[4], s1_q[1], s1_q[5], s1_q[2], s1_q[6]} : rgb_q;
   assign locked = state_q == LOCKED;
   assign pix_valid = pv_q;
   assign pix_x = px_q;
   assign pix_y = py_q;
   assign rgb = rgb_q;
   assign frame_done = fd_q;
   assign timing_err = te_q;
   // lock FSM: sync loss wins, CHECK restarts silently, LOCKED reports failures
   always_comb begin
      state_d = state_q;
      te_d = 1'b0;
      err_d = vs_fall ? 1'b0 : err_q | bad;
      if (lost) begin
         state_d = SEARCH;
         te_d = state_q == LOCKED;
      end else begin
         case (state_q)
            SEARCH: state_d = vs_fall ? CHECK : SEARCH;
            CHECK: state_d = vs_fall ? ((err_q | bad) ? CHECK : LOCKED) : CHECK;
            LOCKED: begin
               state_d = bad ? SEARCH : LOCKED;
               te_d = bad;
            end
            default: state_d = SEARCH;
         endcase
      end
   end
   // input stage, counters, FSM state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SEARCH;
         s1_q <= 8'hFF;
         s2_q <= 2'b11;
         h_q <= '0;
         l_q <= '0;
         err_q <= 1'b0;
         pv_q <= 1'b0;
         fd_q <= 1'b0;
         te_q <= 1'b0;
         px_q <= '0;
         py_q <= '0;
         rgb_q <= '0;
      end else begin
         state_q <= state_d;
         s1_q <= vga_in;
         s2_q <= {s1_q[7], s1_q[3]};
         h_q <= h_cnt;
         l_q <= line_cnt;
         err_q <= err_d;
         pv_q <= pv_d;
         fd_q <= fd_d;
         te_q <= te_d;
         px_q <= px_d;
         py_q <= py_d;
         rgb_q <= rgb_d;
      end
   end
`ifdef VGA_DEC_CRC_EN
   logic [15:0] crc_q, fcrc_q;
   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 7; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
      return r;
   endfunction
   // running CRC over output pixels; seeded while unlocked and at every frame boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_q <= 16'hFFFF;
         fcrc_q <= '0;
      end else begin
         fcrc_q <= fd_q ? crc_q : fcrc_q;
         crc_q <= (fd_q || state_q != LOCKED) ? 16'hFFFF : (pv_q ? crc_step(crc_q, {2'b00, rgb_q}) : crc_q);
      end
   end
   assign frame_crc = fcrc_q;
`else
   assign frame_crc = '0;
`endif
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed bench for vga_sync_decoder on a scaled 40x10 raster (hsync 4, vsync 2 lines, 24x5 active)
`timescale 1ns/1ps
module tb_vga_sync_decoder;
   localparam int HT = 40, HS = 4, HA0 = 8, HA1 = 31, VT = 10, VS = 2, VA0 = 3, VA1 = 7, NPIX = 120;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [7:0] vga_in = 8'hFF;
   logic locked, pix_valid, frame_done, timing_err;
   logic [9:0] pix_x, pix_y;
   logic [5:0] rgb;
   logic [15:0] frame_crc;
   int total = 0, bad = 0, terr_cnt = 0, fd_cnt = 0;
   int prev_h = 0, prev_l = 0, seed = 0;
   logic terr_lk = 1'b1, lk0 = 1'b0, lk1 = 1'b0, solid = 1'b0;
   logic [5:0] prev_c = '0, ex_c = '0;
   logic [9:0] ex_x = '0, ex_y = '0;
   logic [15:0] last_crc = 16'hFFFF;

   always #5 clk = ~clk;

   vga_sync_decoder #(
      .H_TOTAL(10'd40), .H_SYNC(10'd4), .H_ACT0(10'd8), .H_ACT1(10'd31),
      .V_TOTAL(10'd10), .V_SYNC(10'd2), .V_ACT0(10'd3), .V_ACT1(10'd7)
   ) dut (
      .clk(clk), .rst_n(rst_n), .vga_in(vga_in), .locked(locked), .pix_valid(pix_valid),
      .pix_x(pix_x), .pix_y(pix_y), .rgb(rgb), .frame_done(frame_done),
      .timing_err(timing_err), .frame_crc(frame_crc)
   );

   always @(negedge clk) begin
      if (timing_err) begin
         terr_cnt <= terr_cnt + 1;
         terr_lk <= locked;
      end
      if (frame_done) fd_cnt <= fd_cnt + 1;
   end

   function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         if (r[15] ^ d[i]) r = (r << 1) ^ 16'h1021;
         else r = r << 1;
      end
      return r;
   endfunction

   task automatic tick(input logic hs, input logic vs, input logic [5:0] c);
      vga_in = {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input int bl, input int blen, input int stop_at, input logic exp_lock);
      int n, len, pv;
      logic seen, exp_v;
      logic [5:0] c;
      logic [15:0] mcrc;
      n = 0;
      pv = 0;
      seen = 1'b0;
      mcrc = 16'hFFFF;
      seed++;
      for (int l = 0; l < VT; l++) begin
         len = (l == bl) ? blen : HT;
         for (int h = 0; h < len; h++) begin
            if (stop_at >= 0 && n == stop_at) return;
            c = solid ? 6'h3F : 6'(h * 7 + l * 3 + seed);
            tick(h >= HS, l >= VS, c);
            if (n == 0) lk0 = locked;
            if (n == 1) lk1 = locked;
            n++;
            if (pix_valid) pv++;
            exp_v = prev_h >= HA0 && prev_h <= HA1 && prev_l >= VA0 && prev_l <= VA1;
            if (exp_lock) begin
               total++;
               if (pix_valid !== exp_v) begin
                  bad++;
                  $display("FAIL pix_valid line=%0d h=%0d got=%0b exp=%0b", prev_l, prev_h, pix_valid, exp_v);
               end
               if (exp_v) begin
                  seen = 1'b1;
                  ex_x = 10'(prev_h - HA0);
                  ex_y = 10'(prev_l - VA0);
                  ex_c = prev_c;
                  mcrc = crc_upd(mcrc, {2'b00, prev_c});
               end
               if (exp_v || seen) begin
                  total++;
                  if ({pix_x, pix_y, rgb} !== {ex_x, ex_y, ex_c}) begin
                     bad++;
                     $display("FAIL pixel line=%0d h=%0d got x=%0d y=%0d rgb=%h exp x=%0d y=%0d rgb=%h",
                              prev_l, prev_h, pix_x, pix_y, rgb, ex_x, ex_y, ex_c);
                  end
               end
            end
            prev_h = h;
            prev_l = l;
            prev_c = c;
         end
      end
      if (exp_lock) begin
         last_crc = mcrc;
         total++;
         if (pv !== NPIX) begin
            bad++;
            $display("FAIL pix_count got=%0d exp=%0d", pv, NPIX);
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      vga_in = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked got=%b exp=0", locked); end
      total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL rst_pix_valid got=%b exp=0", pix_valid); end
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
      total++; if (timing_err !== 1'b0) begin bad++; $display("FAIL rst_timing_err got=%b exp=0", timing_err); end
      total++; if ({pix_x, pix_y, rgb} !== 26'd0) begin bad++; $display("FAIL rst_pixel got=%h exp=0", {pix_x, pix_y, rgb}); end
      total++; if (frame_crc !== 16'h0000) begin bad++; $display("FAIL rst_frame_crc got=%h exp=0", frame_crc); end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_lock;
      frame(-1, 0, -1, 1'b0);
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_after_check got=%b exp=0", locked); end
      frame(-1, 0, -1, 1'b1);
      total++; if (lk0 !== 1'b0) begin bad++; $display("FAIL lock_before_edge got=%b exp=0", lk0); end
      total++; if (lk1 !== 1'b1) begin bad++; $display("FAIL lock_after_edge got=%b exp=1", lk1); end
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_held got=%b exp=1", locked); end
      total++; if (terr_cnt !== 0) begin bad++; $display("FAIL lock_timing_err got=%0d exp=0", terr_cnt); end
      total++; if (fd_cnt !== 0) begin bad++; $display("FAIL lock_frame_done got=%0d exp=0", fd_cnt); end
   endtask

   task automatic test_pixels;
      int f0;
      logic [15:0] m;
      f0 = fd_cnt;
      frame(-1, 0, -1, 1'b1);
      m = last_crc;
      frame(-1, 0, -1, 1'b1);
      total++; if (fd_cnt !== f0 + 2) begin bad++; $display("FAIL pix_frame_done got=%0d exp=%0d", fd_cnt, f0 + 2); end
`ifdef VGA_DEC_CRC_EN
      total++; if (frame_crc !== m) begin bad++; $display("FAIL pix_frame_crc got=%h exp=%h", frame_crc, m); end
`else
      total++; if (frame_crc !== 16'h0000) begin bad++; $display("FAIL pix_frame_crc got=%h exp=0 (m=%h)", frame_crc, m); end
`endif
   endtask

   task automatic test_bad_line;
      int t0;
      t0 = terr_cnt;
      terr_lk = 1'b1;
      frame(5, 41, -1, 1'b0);
      total++; if (terr_cnt !== t0 + 1) begin bad++; $display("FAIL badline_terr got=%0d exp=%0d", terr_cnt, t0 + 1); end
      total++; if (terr_lk !== 1'b0) begin bad++; $display("FAIL badline_lock_at_err got=%b exp=0", terr_lk); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL badline_locked got=%b exp=0", locked); end
      frame(-1, 0, -1, 1'b0);
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL badline_check got=%b exp=0", locked); end
      frame(-1, 0, -1, 1'b1);
      total++; if (lk1 !== 1'b1) begin bad++; $display("FAIL badline_relock got=%b exp=1", lk1); end
      total++; if (terr_cnt !== t0 + 1) begin bad++; $display("FAIL badline_terr_after got=%0d exp=%0d", terr_cnt, t0 + 1); end
   endtask

   task automatic test_sync_loss;
      int t0;
      t0 = terr_cnt;
      terr_lk = 1'b1;
      for (int i = 0; i < 1104; i++) tick(i >= HS, 1'b1, 6'h15);
      prev_h = 0;
      prev_l = 0;
      total++; if (terr_cnt !== t0 + 1) begin bad++; $display("FAIL loss_terr got=%0d exp=%0d", terr_cnt, t0 + 1); end
      total++; if (terr_lk !== 1'b0) begin bad++; $display("FAIL loss_lock_at_err got=%b exp=0", terr_lk); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL loss_locked got=%b exp=0", locked); end
      frame(5, 41, -1, 1'b0);
      total++; if (terr_cnt !== t0 + 1) begin bad++; $display("FAIL check_bad_terr got=%0d exp=%0d", terr_cnt, t0 + 1); end
      frame(-1, 0, -1, 1'b0);
      total++; if (lk1 !== 1'b0) begin bad++; $display("FAIL check_restart got=%b exp=0", lk1); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL check_restart_end got=%b exp=0", locked); end
      frame(-1, 0, -1, 1'b1);
      total++; if (lk1 !== 1'b1) begin bad++; $display("FAIL loss_relock got=%b exp=1", lk1); end
   endtask

   task automatic test_reset_mid;
      frame(-1, 0, 5 * HT + 15, 1'b1);
      total++; if ({locked, pix_valid} !== 2'b11) begin bad++; $display("FAIL mid_pre got=%b exp=11", {locked, pix_valid}); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL mid_locked got=%b exp=0", locked); end
      total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL mid_pix_valid got=%b exp=0", pix_valid); end
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL mid_frame_done got=%b exp=0", frame_done); end
      vga_in = 8'hFF;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      frame(-1, 0, -1, 1'b0);
      total++; if (lk1 !== 1'b0) begin bad++; $display("FAIL mid_no_early_lock got=%b exp=0", lk1); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL mid_check_end got=%b exp=0", locked); end
      frame(-1, 0, -1, 1'b1);
      total++; if (lk1 !== 1'b1) begin bad++; $display("FAIL mid_relock got=%b exp=1", lk1); end
   endtask

   task automatic test_crc;
      logic [15:0] m;
      solid = 1'b1;
      frame(-1, 0, -1, 1'b1);
      m = last_crc;
      for (int k = 0; k < 2; k++) begin
         frame(-1, 0, -1, 1'b1);
`ifdef VGA_DEC_CRC_EN
         total++; if (frame_crc !== m) begin bad++; $display("FAIL crc_solid_%0d got=%h exp=%h", k, frame_crc, m); end
`else
         total++; if (frame_crc !== 16'h0000) begin bad++; $display("FAIL crc_solid_%0d got=%h exp=0", k, frame_crc); end
`endif
      end
      solid = 1'b0;
   endtask

   initial begin
      test_reset;
      test_lock;
      test_pixels;
      test_bad_line;
      test_sync_loss;
      test_reset_mid;
      test_crc;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
